// File: rtl/tx_logic_disp.sv
// PCIe 8b/10b Tx logical-layer control: passes DLL symbols, inserts ordered sets
// and logical idle, and drives per-symbol scrambler controls toward the encoder.
module tx_logic_disp #(
    parameter int SKP_INTERVAL = 1180
) (
    input  logic       Clk,
    input  logic       notReset,
    input  logic [7:0] TxByte,
    input  logic       TxCtrl,
    input  logic       TxValid,
    output logic       TxReady,
    input  logic       TxInPkt,
    input  logic [1:0] SendTS,
    input  logic [7:0] TsLinkNum,
    input  logic [7:0] TsLaneNum,
    input  logic [7:0] TsNFts,
    input  logic [7:0] TsRateId,
    input  logic [7:0] TsTrainCtl,
    input  logic       SendEios,
    input  logic       SendFts,
    input  logic       SkpEnable,
    input  logic       DisableScramble,
    output logic [7:0] EncodeByte,
    output logic       EncodeCtrl,
    output logic       notResetScrambler,
    output logic       MoveScrambler,
    output logic       Scramble,
    output logic       OsDone
);
    localparam int CW = $clog2(SKP_INTERVAL) + 1;
    localparam logic [CW-1:0] SKP_DUE_AT = CW'(SKP_INTERVAL - 1);
    localparam logic [7:0] K_COM  = 8'hBC;
    localparam logic [7:0] K_SKP  = 8'h1C;
    localparam logic [7:0] K_IDL  = 8'h7C;
    localparam logic [7:0] K_FTS  = 8'h3C;
    localparam logic [7:0] K_PAD  = 8'hF7;
    localparam logic [7:0] TS1_ID = 8'h4A;
    localparam logic [7:0] TS2_ID = 8'h45;

    typedef enum logic [2:0] {ST_DATA, ST_TS, ST_SKP, ST_EIOS, ST_FTS} state_e;

    state_e        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [CW-1:0] skp_cnt_q, skp_cnt_d;
    logic [7:0]    fts_rem_q, fts_rem_d;
    logic          fts_tail_q, fts_tail_d;
    logic          ts2_q, ts2_d;
    logic [7:0]    link_q, link_d, lane_q, lane_d, nfts_q, nfts_d, rate_q, rate_d, tctl_q, tctl_d;
    logic [7:0]    byte_q, byte_d;
    logic          ctrl_q, ctrl_d, nrst_q, nrst_d, move_q, move_d, scr_q, scr_d, done_q, done_d;

    logic skp_due, start_skp, start_eios, start_ts, start_fts, os_start, in_ts;

    always_comb begin
        skp_due    = SkpEnable && (skp_cnt_q >= SKP_DUE_AT);
        start_skp  = (state_q == ST_DATA) && skp_due && !TxInPkt;
        start_eios = (state_q == ST_DATA) && !start_skp && SendEios;
        start_ts   = (state_q == ST_DATA) && !start_skp && !SendEios && (SendTS != 2'b00);
        start_fts  = (state_q == ST_DATA) && !start_skp && !SendEios && (SendTS == 2'b00) && SendFts;
        os_start   = start_skp || start_eios || start_ts || start_fts;
        TxReady    = notReset && (state_q == ST_DATA) && !os_start;
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q + 4'd1;
        fts_rem_d  = fts_rem_q;
        fts_tail_d = fts_tail_q;
        ts2_d      = ts2_q;
        link_d     = link_q;
        lane_d     = lane_q;
        nfts_d     = nfts_q;
        rate_d     = rate_q;
        tctl_d     = tctl_q;
        byte_d     = 8'h00;
        ctrl_d     = 1'b0;
        in_ts      = 1'b0;
        done_d     = 1'b0;
        skp_cnt_d  = (skp_cnt_q == '1) ? skp_cnt_q : skp_cnt_q + CW'(1);

        case (state_q)
            ST_DATA: begin
                idx_d = 4'd1;
                if (os_start) begin
                    byte_d = K_COM;
                    ctrl_d = 1'b1;
                end else if (TxValid) begin
                    byte_d = TxByte;
                    ctrl_d = TxCtrl;
                end
                if (start_skp) begin
                    state_d   = ST_SKP;
                    skp_cnt_d = '0;
                end
                if (start_eios) state_d = ST_EIOS;
                if (start_ts) begin
                    state_d = ST_TS;
                    in_ts   = 1'b1;
                    ts2_d   = SendTS[1];
                    link_d  = TsLinkNum;
                    lane_d  = TsLaneNum;
                    nfts_d  = TsNFts;
                    rate_d  = TsRateId;
                    tctl_d  = TsTrainCtl;
                end
                if (start_fts) begin
                    state_d   = ST_FTS;
                    // fts_rem counts sets still owed after the one starting now
                    fts_rem_d = (TsNFts == 8'd0) ? 8'd0 : TsNFts - 8'd1;
                end
            end
            ST_TS: begin
                in_ts = 1'b1;
                case (idx_q)
                    4'd1: begin byte_d = link_q; ctrl_d = (link_q == K_PAD); end
                    4'd2: begin byte_d = lane_q; ctrl_d = (lane_q == K_PAD); end
                    4'd3: byte_d = nfts_q;
                    4'd4: byte_d = rate_q;
                    4'd5: byte_d = tctl_q;
                    default: byte_d = ts2_q ? TS2_ID : TS1_ID;
                endcase
                if (idx_q == 4'd15) begin
                    state_d = ST_DATA;
                    done_d  = 1'b1;
                end
            end
            ST_SKP: begin
                ctrl_d = 1'b1;
                byte_d = (idx_q == 4'd0) ? K_COM : K_SKP;
                if (idx_q == 4'd3) begin
                    state_d    = ST_DATA;
                    done_d     = fts_tail_q;
                    fts_tail_d = 1'b0;
                end
            end
            ST_EIOS: begin
                ctrl_d = 1'b1;
                byte_d = K_IDL;
                if (idx_q == 4'd3) begin
                    state_d = ST_DATA;
                    done_d  = 1'b1;
                end
            end
            ST_FTS: begin
                ctrl_d = 1'b1;
                byte_d = (idx_q == 4'd0) ? K_COM : K_FTS;
                if (idx_q == 4'd3) begin
                    idx_d = 4'd0;
                    if (fts_rem_q != 8'd0) begin
                        fts_rem_d = fts_rem_q - 8'd1;
                    end else begin
                        state_d    = ST_SKP;
                        fts_tail_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_DATA;
        endcase

        nrst_d = !(ctrl_d && byte_d == K_COM);
        move_d = !(ctrl_d && byte_d == K_SKP);
        scr_d  = !ctrl_d && !in_ts && !DisableScramble;
    end

    always_ff @(posedge Clk) begin
        if (!notReset) begin
            state_q    <= ST_DATA;
            idx_q      <= 4'd0;
            skp_cnt_q  <= '0;
            fts_rem_q  <= 8'd0;
            fts_tail_q <= 1'b0;
            ts2_q      <= 1'b0;
            link_q     <= 8'd0;
            lane_q     <= 8'd0;
            nfts_q     <= 8'd0;
            rate_q     <= 8'd0;
            tctl_q     <= 8'd0;
            byte_q     <= 8'd0;
            ctrl_q     <= 1'b0;
            nrst_q     <= 1'b0;
            move_q     <= 1'b0;
            scr_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            skp_cnt_q  <= skp_cnt_d;
            fts_rem_q  <= fts_rem_d;
            fts_tail_q <= fts_tail_d;
            ts2_q      <= ts2_d;
            link_q     <= link_d;
            lane_q     <= lane_d;
            nfts_q     <= nfts_d;
            rate_q     <= rate_d;
            tctl_q     <= tctl_d;
            byte_q     <= byte_d;
            ctrl_q     <= ctrl_d;
            nrst_q     <= nrst_d;
            move_q     <= move_d;
            scr_q      <= scr_d;
            done_q     <= done_d;
        end
    end

    assign EncodeByte        = byte_q;
    assign EncodeCtrl        = ctrl_q;
    assign notResetScrambler = nrst_q;
    assign MoveScrambler     = move_q;
    assign Scramble          = scr_q;
    assign OsDone            = done_q;
endmodule

// File: tb/tb_tx_logic_disp.sv
// Bench for tx_logic_disp: directed ordered-set sequences plus DLL traffic
// checked against a queue-based model of symbol flow and SKP insertion.
`timescale 1ns/1ps
module tb_tx_logic_disp;
    localparam int SKP_INT = 16;
    localparam logic [7:0] COM = 8'hBC, SKP = 8'h1C, IDL = 8'h7C, FTS = 8'h3C, PAD = 8'hF7;

    logic       Clk = 1'b0;
    logic       notReset = 1'b0;
    logic [7:0] TxByte = 8'h00;
    logic       TxCtrl = 1'b0, TxValid = 1'b0, TxInPkt = 1'b0;
    logic [1:0] SendTS = 2'b00;
    logic [7:0] TsLinkNum = 8'h00, TsLaneNum = 8'h00, TsNFts = 8'h00, TsRateId = 8'h00, TsTrainCtl = 8'h00;
    logic       SendEios = 1'b0, SendFts = 1'b0, SkpEnable = 1'b0, DisableScramble = 1'b0;
    logic       TxReady, EncodeCtrl, notResetScrambler, MoveScrambler, Scramble, OsDone;
    logic [7:0] EncodeByte;
    logic [12:0] obs;

    int total = 0;
    int bad = 0;
    int m_since;
    logic [8:0] m_pend[$];
    logic [8:0] ts_exp[16];

    always #5 Clk = ~Clk;

    tx_logic_disp #(.SKP_INTERVAL(SKP_INT)) dut (
        .Clk(Clk), .notReset(notReset), .TxByte(TxByte), .TxCtrl(TxCtrl), .TxValid(TxValid),
        .TxReady(TxReady), .TxInPkt(TxInPkt), .SendTS(SendTS), .TsLinkNum(TsLinkNum),
        .TsLaneNum(TsLaneNum), .TsNFts(TsNFts), .TsRateId(TsRateId), .TsTrainCtl(TsTrainCtl),
        .SendEios(SendEios), .SendFts(SendFts), .SkpEnable(SkpEnable),
        .DisableScramble(DisableScramble), .EncodeByte(EncodeByte), .EncodeCtrl(EncodeCtrl),
        .notResetScrambler(notResetScrambler), .MoveScrambler(MoveScrambler),
        .Scramble(Scramble), .OsDone(OsDone)
    );

    assign obs = {OsDone, Scramble, MoveScrambler, notResetScrambler, EncodeCtrl, EncodeByte};

    // Expected output bundle for one symbol, from the scrambler-control rules.
    function automatic logic [12:0] exp_out(input logic k, input logic [7:0] b, input logic ts,
                                            input logic dis, input logic done);
        return {done, !k && !ts && !dis, !(k && b == SKP), !(k && b == COM), k, b};
    endfunction

    // One symbol time of the reference: pending OS symbols first, then SKP if due, else DLL/idle.
    function automatic void model_step(input logic v, input logic [7:0] b, input logic c,
                                       input logic inpkt, input logic en,
                                       output logic [8:0] sym, output logic rdy);
        if (m_pend.size() != 0) begin
            sym = m_pend.pop_front();
            rdy = 1'b0;
        end else if (en && m_since >= SKP_INT - 1 && !inpkt) begin
            sym = {1'b1, COM};
            for (int j = 0; j < 3; j++) m_pend.push_back({1'b1, SKP});
            rdy = 1'b0;
            m_since = -1;
        end else begin
            rdy = 1'b1;
            sym = v ? {c, b} : 9'h000;
        end
        m_since++;
    endfunction

    task automatic fill_ts(input logic [7:0] link, input logic [7:0] lane, input logic [7:0] nf,
                           input logic [7:0] rate, input logic [7:0] tctl, input logic [7:0] id);
        ts_exp[0] = {1'b1, COM};
        ts_exp[1] = {link == PAD, link};
        ts_exp[2] = {lane == PAD, lane};
        ts_exp[3] = {1'b0, nf};
        ts_exp[4] = {1'b0, rate};
        ts_exp[5] = {1'b0, tctl};
        for (int j = 6; j < 16; j++) ts_exp[j] = {1'b0, id};
    endtask

    task automatic do_reset();
        notReset = 1'b0;
        TxByte = 8'h00; TxCtrl = 1'b0; TxValid = 1'b0; TxInPkt = 1'b0; SendTS = 2'b00;
        TsLinkNum = 8'h00; TsLaneNum = 8'h00; TsNFts = 8'h00; TsRateId = 8'h00; TsTrainCtl = 8'h00;
        SendEios = 1'b0; SendFts = 1'b0; SkpEnable = 1'b0; DisableScramble = 1'b0;
        repeat (2) @(negedge Clk);
        notReset = 1'b1;
        m_since = 0;
        m_pend.delete();
    endtask

    task automatic test_reset();
        notReset = 1'b0; TxValid = 1'b1; TxByte = 8'h5A; SendTS = 2'b01; SkpEnable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            total++;
            if (obs !== 13'h0) begin bad++; $display("FAIL reset_outputs got=%h want=%h", obs, 13'h0); end
            total++;
            if (TxReady !== 1'b0) begin bad++; $display("FAIL reset_txready got=%b want=0", TxReady); end
        end
    endtask

    task automatic test_idle();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            #1;
            total++;
            if (TxReady !== 1'b1) begin bad++; $display("FAIL idle_txready cyc=%0d got=%b want=1", i, TxReady); end
            @(negedge Clk);
            total++;
            if (obs !== exp_out(1'b0, 8'h00, 1'b0, 1'b0, 1'b0))
                begin bad++; $display("FAIL idle_sym cyc=%0d got=%h want=%h", i, obs, exp_out(1'b0, 8'h00, 1'b0, 1'b0, 1'b0)); end
        end
    endtask

    task automatic test_ts();
        do_reset();
        SendTS = 2'b01; TsLinkNum = 8'h00; TsLaneNum = PAD; TsNFts = 8'h1F; TsRateId = 8'h02; TsTrainCtl = 8'h00;
        TxValid = 1'b1; TxByte = 8'hA5; TxCtrl = 1'b0;
        fill_ts(8'h00, PAD, 8'h1F, 8'h02, 8'h00, 8'h4A);
        #1;
        total++;
        if (TxReady !== 1'b0) begin bad++; $display("FAIL ts_start_ready got=%b want=0", TxReady); end
        for (int k = 0; k < 16; k++) begin
            @(negedge Clk);
            if (k == 0) begin SendTS = 2'b00; TsLinkNum = 8'h55; TsLaneNum = 8'h66; end
            total++;
            if (obs !== exp_out(ts_exp[k][8], ts_exp[k][7:0], 1'b1, 1'b0, k == 15))
                begin bad++; $display("FAIL ts1_sym idx=%0d got=%h want=%h", k, obs, exp_out(ts_exp[k][8], ts_exp[k][7:0], 1'b1, 1'b0, k == 15)); end
            #1;
            total++;
            if (TxReady !== (k == 15)) begin bad++; $display("FAIL ts1_ready idx=%0d got=%b want=%b", k, TxReady, k == 15); end
        end
        @(negedge Clk);
        TxValid = 1'b0;
        total++;
        if (obs !== exp_out(1'b0, 8'hA5, 1'b0, 1'b0, 1'b0))
            begin bad++; $display("FAIL ts1_held_byte got=%h want=%h", obs, exp_out(1'b0, 8'hA5, 1'b0, 1'b0, 1'b0)); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        SendTS = 2'b11; TsLinkNum = PAD; TsLaneNum = 8'h03; TsNFts = 8'h08; TsRateId = 8'h06; TsTrainCtl = 8'h08;
        fill_ts(PAD, 8'h03, 8'h08, 8'h06, 8'h08, 8'h45);
        for (int k = 0; k < 32; k++) begin
            @(negedge Clk);
            if (k == 16) SendTS = 2'b00;
            total++;
            if (obs !== exp_out(ts_exp[k % 16][8], ts_exp[k % 16][7:0], 1'b1, 1'b0, (k % 16) == 15))
                begin bad++; $display("FAIL ts2_b2b_sym k=%0d got=%h want=%h", k, obs, exp_out(ts_exp[k % 16][8], ts_exp[k % 16][7:0], 1'b1, 1'b0, (k % 16) == 15)); end
            #1;
            total++;
            if (TxReady !== (k == 31)) begin bad++; $display("FAIL ts2_b2b_ready k=%0d got=%b want=%b", k, TxReady, k == 31); end
        end
        @(negedge Clk);
        total++;
        if (obs !== exp_out(1'b0, 8'h00, 1'b0, 1'b0, 1'b0))
            begin bad++; $display("FAIL ts2_b2b_after got=%h want=%h", obs, exp_out(1'b0, 8'h00, 1'b0, 1'b0, 1'b0)); end
    endtask

    task automatic test_fts();
        for (int r = 0; r < 2; r++) begin
            int sets, len;
            logic [7:0] eb;
            do_reset();
            TsNFts = (r == 0) ? 8'd2 : 8'd0;
            sets = (r == 0) ? 2 : 1;
            len = 4 * sets + 4;
            SendFts = 1'b1;
            for (int k = 0; k < len; k++) begin
                @(negedge Clk);
                if (k == 0) SendFts = 1'b0;
                if (k < 4 * sets) eb = (k % 4 == 0) ? COM : FTS;
                else eb = (k == 4 * sets) ? COM : SKP;
                total++;
                if (obs !== exp_out(1'b1, eb, 1'b0, 1'b0, k == len - 1))
                    begin bad++; $display("FAIL fts_sym n=%0d k=%0d got=%h want=%h", TsNFts, k, obs, exp_out(1'b1, eb, 1'b0, 1'b0, k == len - 1)); end
                #1;
                total++;
                if (TxReady !== (k == len - 1)) begin bad++; $display("FAIL fts_ready k=%0d got=%b want=%b", k, TxReady, k == len - 1); end
            end
        end
    endtask

    task automatic test_eios_reset();
        do_reset();
        SendEios = 1'b1; SendTS = 2'b01; SendFts = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            if (k == 0) begin SendEios = 1'b0; SendTS = 2'b00; SendFts = 1'b0; end
            total++;
            if (obs !== exp_out(1'b1, (k == 0) ? COM : IDL, 1'b0, 1'b0, k == 3))
                begin bad++; $display("FAIL eios_sym k=%0d got=%h want=%h", k, obs, exp_out(1'b1, (k == 0) ? COM : IDL, 1'b0, 1'b0, k == 3)); end
        end
        SendEios = 1'b1;
        @(negedge Clk);
        SendEios = 1'b0;
        total++;
        if (obs !== exp_out(1'b1, COM, 1'b0, 1'b0, 1'b0)) begin bad++; $display("FAIL eios2_com got=%h", obs); end
        @(negedge Clk);
        notReset = 1'b0;
        @(negedge Clk);
        total++;
        if (obs !== 13'h0) begin bad++; $display("FAIL eios_mid_reset got=%h want=%h", obs, 13'h0); end
        total++;
        if (TxReady !== 1'b0) begin bad++; $display("FAIL eios_reset_ready got=%b want=0", TxReady); end
        notReset = 1'b1;
        #1;
        total++;
        if (TxReady !== 1'b1) begin bad++; $display("FAIL eios_release_ready got=%b want=1", TxReady); end
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            total++;
            if (obs !== exp_out(1'b0, 8'h00, 1'b0, 1'b0, 1'b0))
                begin bad++; $display("FAIL eios_after_reset k=%0d got=%h want=%h", k, obs, exp_out(1'b0, 8'h00, 1'b0, 1'b0, 1'b0)); end
        end
    endtask

    // mode 0: continuous data, periodic SKP; 1: SKP deferred by TxInPkt; 2: random traffic
    task automatic test_traffic(input int mode);
        int ncyc, n_com, first_com;
        logic [8:0] esym;
        logic erdy, acc, e_dis;
        logic [7:0] next_b;
        do_reset();
        SkpEnable = 1'b1;
        ncyc = (mode == 0) ? 64 : (mode == 1) ? 60 : 400;
        n_com = 0; first_com = -1; acc = 1'b1; next_b = 8'h00;
        for (int i = 0; i < ncyc; i++) begin
            if (mode == 2) begin
                if (!(TxValid && !acc)) begin
                    TxValid = ($urandom_range(0, 3) != 0);
                    TxByte = 8'($urandom);
                    TxCtrl = ($urandom_range(0, 7) == 0);
                end
                if ($urandom_range(0, 9) == 0) TxInPkt = ~TxInPkt;
                DisableScramble = ($urandom_range(0, 7) == 0);
            end else begin
                TxValid = 1'b1;
                if (i != 0 && acc) TxByte = TxByte + 8'd1;
                TxInPkt = (mode == 1) && (i < 40);
            end
            model_step(TxValid, TxByte, TxCtrl, TxInPkt, SkpEnable, esym, erdy);
            e_dis = DisableScramble;
            acc = erdy && TxValid;
            #1;
            total++;
            if (TxReady !== erdy) begin bad++; $display("FAIL traffic%0d_ready cyc=%0d got=%b want=%b", mode, i, TxReady, erdy); end
            @(negedge Clk);
            total++;
            if (obs !== exp_out(esym[8], esym[7:0], 1'b0, e_dis, 1'b0))
                begin bad++; $display("FAIL traffic%0d_sym cyc=%0d got=%h want=%h", mode, i, obs, exp_out(esym[8], esym[7:0], 1'b0, e_dis, 1'b0)); end
            if (EncodeCtrl && EncodeByte == COM) begin
                n_com++;
                if (first_com < 0) first_com = i;
            end
            if (mode == 0 && !EncodeCtrl) begin
                total++;
                if (EncodeByte !== next_b) begin bad++; $display("FAIL skp_order cyc=%0d got=%h want=%h", i, EncodeByte, next_b); end
                next_b = next_b + 8'd1;
            end
        end
        if (mode == 0) begin
            total++;
            if (n_com != ncyc / SKP_INT) begin bad++; $display("FAIL skp_periodic_count got=%0d want=%0d", n_com, ncyc / SKP_INT); end
        end
        if (mode == 1) begin
            total++;
            if (first_com != 40) begin bad++; $display("FAIL skp_defer_first got=%0d want=40", first_com); end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_ts();
        test_back_to_back();
        test_fts();
        test_eios_reset();
        test_traffic(0);
        test_traffic(1);
        test_traffic(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
